// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single-ported data memory between the ASIP
//                load/store port (priority) and a DMA requester. A wait
//                counter bounds DMA starvation; a beat counter caps the
//                length of a DMA burst ownership.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int WIDTH     = 17,
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    // ASIP data port
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic [WIDTH-1:0] cpu_rd,
    output logic             cpu_stall,
    // DMA port
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [WIDTH-1:0] dma_adr,
    input  logic [WIDTH-1:0] dma_wd,
    input  logic             dma_last,
    output logic             dma_gnt,
    output logic [WIDTH-1:0] dma_rd,
    output logic             dma_rvalid,
    // Data memory
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int C_WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int C_BEAT_W = $clog2(BURST_MAX + 1);
    localparam logic [C_WAIT_W-1:0] C_WAIT_MAX = C_WAIT_W'(MAX_WAIT);
    localparam logic [C_BEAT_W-1:0] C_BEAT_CAP = C_BEAT_W'(BURST_MAX);

    typedef enum logic [0:0] {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } owner_t;

    owner_t                owner_q,    owner_d;
    logic [C_WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [C_BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0]      dma_rd_q,   dma_rd_d;
    logic                  dma_rvalid_q, dma_rvalid_d;

    owner_t                w_owner;
    logic                  w_wait_full;
    logic                  w_dma_win;
    logic                  w_cpu_win;
    logic [C_BEAT_W-1:0]   w_beat_next;

    // Arbitration and memory-port steering; reset forces the CPU-owned view
    always_comb begin
        w_owner     = reset ? CPU_OWN : owner_q;
        w_wait_full = !reset && (wait_cnt_q == C_WAIT_MAX);
        w_dma_win   = 1'b0;
        mem_we      = 1'b0;
        mem_adr     = '0;
        mem_wd      = '0;

        if (w_owner == DMA_OWN) begin
            w_dma_win = dma_req;
        end else begin
            w_dma_win = dma_req && (!cpu_req || w_wait_full);
        end
        w_cpu_win = cpu_req && !w_dma_win;

        if (w_dma_win) begin
            mem_we  = dma_we;
            mem_adr = dma_adr;
            mem_wd  = dma_wd;
        end else if (w_cpu_win) begin
            mem_we  = cpu_we;
            mem_adr = cpu_adr;
            mem_wd  = cpu_wd;
        end

        dma_gnt   = w_dma_win;
        cpu_stall = w_dma_win && cpu_req;
    end

    // Ownership, starvation and burst-length bookkeeping plus DMA read capture
    always_comb begin
        owner_d      = owner_q;
        wait_cnt_d   = wait_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        dma_rd_d     = dma_rd_q;
        dma_rvalid_d = 1'b0;
        w_beat_next  = beat_cnt_q + C_BEAT_W'(1);

        if (w_dma_win) begin
            wait_cnt_d = '0;
            // A last beat coinciding with the cap is a single hand-back
            if (dma_last || (w_beat_next == C_BEAT_CAP)) begin
                owner_d    = CPU_OWN;
                beat_cnt_d = '0;
            end else begin
                owner_d    = DMA_OWN;
                beat_cnt_d = w_beat_next;
            end
            if (!dma_we) begin
                dma_rd_d     = mem_rd;
                dma_rvalid_d = 1'b1;
            end
        end else if (owner_q == DMA_OWN) begin
            // DMA dropped its request mid-burst: give the memory back
            owner_d    = CPU_OWN;
            beat_cnt_d = '0;
            wait_cnt_d = '0;
        end else begin
            beat_cnt_d = '0;
            if (dma_req && cpu_req) begin
                if (wait_cnt_q != C_WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + C_WAIT_W'(1);
                end
            end else begin
                wait_cnt_d = '0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= CPU_OWN;
            wait_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            dma_rd_q     <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            dma_rd_q     <= dma_rd_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    assign cpu_rd     = mem_rd;
    assign dma_rd     = dma_rd_q;
    assign dma_rvalid = dma_rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: a memory, a
//                rule-level reference model compared every cycle, and
//                directed scenarios with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int WIDTH     = 17;
    localparam int MAX_WAIT  = 8;
    localparam int BURST_MAX = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_req, cpu_we;
    logic [WIDTH-1:0] cpu_adr, cpu_wd, cpu_rd;
    logic             cpu_stall;
    logic             dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
    logic [WIDTH-1:0] dma_adr, dma_wd, dma_rd;
    logic             mem_we;
    logic [WIDTH-1:0] mem_adr, mem_wd, mem_rd;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] ram    [0:255];
    logic [WIDTH-1:0] shadow [0:255];

    dmem_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_WAIT (MAX_WAIT),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_adr   (dma_adr),
        .dma_wd    (dma_wd),
        .dma_last  (dma_last),
        .dma_gnt   (dma_gnt),
        .dma_rd    (dma_rd),
        .dma_rvalid(dma_rvalid),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] init_val(input int a);
        return WIDTH'(32'h100 + a * 3);
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Data memory: combinational read, write on the clock edge
    assign mem_rd = ram[mem_adr[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_adr[7:0]] <= mem_wd;
        end
    end

    // Reference model: ownership expressed as burst / beats-taken / contended-cycles
    initial begin
        bit               m_burst, burst_now, dwin, cwin, e_we, exp_rv;
        int               m_beats, m_wait, wait_now;
        logic [WIDTH-1:0] e_adr, e_wd, exp_drd;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        m_burst = 0; m_beats = 0; m_wait = 0; exp_rv = 0; exp_drd = '0;
        forever begin
            @(negedge clk);
            burst_now = reset ? 1'b0 : m_burst;
            wait_now  = reset ? 0 : m_wait;
            dwin = dma_req && (burst_now || !cpu_req || wait_now >= MAX_WAIT);
            cwin = cpu_req && !dwin;
            if (dwin) begin
                e_we = dma_we; e_adr = dma_adr; e_wd = dma_wd;
            end else if (cwin) begin
                e_we = cpu_we; e_adr = cpu_adr; e_wd = cpu_wd;
            end else begin
                e_we = 1'b0; e_adr = '0; e_wd = '0;
            end
            chk1("dma_gnt",    dma_gnt,    dwin);
            chk1("cpu_stall",  cpu_stall,  dwin && cpu_req);
            chk1("mem_we",     mem_we,     e_we);
            chkw("mem_adr",    mem_adr,    e_adr);
            chkw("mem_wd",     mem_wd,     e_wd);
            chkw("cpu_rd",     cpu_rd,     shadow[e_adr[7:0]]);
            chk1("dma_rvalid", dma_rvalid, exp_rv);
            chkw("dma_rd",     dma_rd,     exp_drd);

            exp_rv = 1'b0;
            if (reset) begin
                m_burst = 0; m_beats = 0; m_wait = 0; exp_drd = '0;
            end else if (dwin) begin
                if (!dma_we) begin
                    exp_rv  = 1'b1;
                    exp_drd = shadow[dma_adr[7:0]];
                end
                m_beats++;
                m_wait = 0;
                if (dma_last || m_beats >= BURST_MAX) begin
                    m_burst = 0; m_beats = 0;
                end else begin
                    m_burst = 1;
                end
            end else if (m_burst) begin
                m_burst = 0; m_beats = 0; m_wait = 0;
            end else if (dma_req && cpu_req) begin
                if (m_wait < MAX_WAIT) m_wait++;
            end else begin
                m_wait = 0;
            end
            if (e_we) shadow[e_adr[7:0]] = e_wd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        cpu_req = r; cpu_we = w; cpu_adr = a; cpu_wd = d;
    endtask

    task automatic set_dma(input logic r, input logic w, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] d, input logic l);
        dma_req = r; dma_we = w; dma_adr = a; dma_wd = d; dma_last = l;
    endtask

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Directed scenarios
    initial begin
        int first_g, last_g, n_g, beat;
        int g[$];
        int exp_g[6];
        exp_g[0] = 9; exp_g[1] = 10; exp_g[2] = 11; exp_g[3] = 12; exp_g[4] = 21; exp_g[5] = 22;

        reset = 1'b1;
        set_cpu(0, 0, '0, '0);
        set_dma(0, 0, '0, '0, 0);
        tick(); tick();
        sample();
        chk1("rst_rvalid", dma_rvalid, 1'b0);
        chkw("rst_dma_rd", dma_rd, '0);
        chk1("rst_gnt", dma_gnt, 1'b0);
        tick();
        reset = 1'b0;

        // CPU write then read back
        set_cpu(1, 1, 17'd5, 17'h1ABCD);
        sample();
        chk1("t1_we", mem_we, 1'b1);
        chkw("t1_adr", mem_adr, 17'd5);
        chkw("t1_wd", mem_wd, 17'h1ABCD);
        chk1("t1_stall", cpu_stall, 1'b0);
        tick();
        set_cpu(1, 0, 17'd5, '0);
        sample();
        chkw("t1_rd", cpu_rd, 17'h1ABCD);
        chk1("t1_gnt", dma_gnt, 1'b0);
        tick();

        // DMA-only three-beat read burst
        set_cpu(0, 0, '0, '0);
        set_dma(1, 0, 17'd10, '0, 0);
        sample(); chk1("t2_gnt1", dma_gnt, 1'b1);
        tick();
        set_dma(1, 0, 17'd11, '0, 0);
        sample(); chk1("t2_gnt2", dma_gnt, 1'b1); chkw("t2_rd1", dma_rd, 17'h11E);
        tick();
        set_dma(1, 0, 17'd12, '0, 1);
        sample(); chk1("t2_gnt3", dma_gnt, 1'b1); chkw("t2_rd2", dma_rd, 17'h121);
        tick();
        set_dma(0, 0, '0, '0, 0);
        sample(); chk1("t2_rv3", dma_rvalid, 1'b1); chkw("t2_rd3", dma_rd, 17'h124);
        tick();
        sample(); chk1("t2_rv_end", dma_rvalid, 1'b0); chkw("t2_rd_hold", dma_rd, 17'h124);
        tick();

        // Continuous contention with single-beat DMA
        set_cpu(1, 0, 17'd1, '0);
        set_dma(1, 1, 17'd20, 17'h00777, 1);
        first_g = 0; last_g = 0; n_g = 0;
        for (int c = 1; c <= 18; c++) begin
            sample();
            if (dma_gnt) begin
                n_g++;
                if (first_g == 0) first_g = c;
                last_g = c;
            end
            tick();
        end
        chki("t3_first_grant", first_g, 9);
        chki("t3_last_grant", last_g, 18);
        chki("t3_grants", n_g, 2);
        set_cpu(0, 0, '0, '0);
        set_dma(0, 0, '0, '0, 0);
        tick();

        // Burst cap with the CPU requesting throughout
        set_cpu(1, 0, 17'd2, '0);
        beat = 0;
        for (int c = 1; c <= 40 && beat < 6; c++) begin
            set_dma(1, 1, WIDTH'(40 + beat), WIDTH'(32'h1000 + beat), 0);
            sample();
            if (dma_gnt) begin
                g.push_back(c);
                beat++;
            end
            tick();
        end
        chki("t4_beats", g.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < g.size()) chki("t4_grant_cycle", g[i], exp_g[i]);
        end
        set_dma(0, 0, '0, '0, 0);
        set_cpu(1, 0, 17'd45, '0);
        sample(); chkw("t4_readback", cpu_rd, 17'h1005); chk1("t4_stall", cpu_stall, 1'b0);
        tick();
        set_cpu(0, 0, '0, '0);
        tick();

        // Abandoned burst, then a full capped burst proving the beat count restarted
        set_dma(1, 1, 17'd60, 17'h60, 0);
        sample(); chk1("t5_gnt1", dma_gnt, 1'b1);
        tick();
        set_cpu(1, 0, 17'd3, '0);
        set_dma(1, 1, 17'd61, 17'h61, 0);
        sample(); chk1("t5_gnt2", dma_gnt, 1'b1); chk1("t5_stall2", cpu_stall, 1'b1);
        tick();
        set_dma(0, 0, '0, '0, 0);
        sample(); chk1("t5_gnt_drop", dma_gnt, 1'b0); chk1("t5_stall_drop", cpu_stall, 1'b0);
        chkw("t5_adr_drop", mem_adr, 17'd3);
        tick();
        set_dma(1, 1, 17'd62, 17'h62, 0);
        sample(); chk1("t5_cpu_owns", dma_gnt, 1'b0);
        tick();
        set_cpu(0, 0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            set_dma(1, 1, WIDTH'(62 + k), WIDTH'(32'h62 + k), 0);
            sample(); chk1("t5_burst_gnt", dma_gnt, 1'b1);
            tick();
        end
        set_cpu(1, 0, 17'd3, '0);
        set_dma(1, 1, 17'd65, 17'h65, 0);
        sample(); chk1("t5_beat4_gnt", dma_gnt, 1'b1); chk1("t5_beat4_stall", cpu_stall, 1'b1);
        tick();
        set_dma(1, 1, 17'd66, 17'h66, 0);
        sample(); chk1("t5_after_cap", dma_gnt, 1'b0);
        tick();
        set_cpu(0, 0, '0, '0);
        set_dma(0, 0, '0, '0, 0);
        tick();

        // Reset during beat 2 of a DMA read burst
        set_dma(1, 0, 17'd10, '0, 0);
        sample(); chk1("t6_gnt1", dma_gnt, 1'b1);
        tick();
        reset = 1'b1;
        set_dma(1, 0, 17'd11, '0, 0);
        sample(); chk1("t6_rv1", dma_rvalid, 1'b1); chkw("t6_rd1", dma_rd, 17'h11E);
        tick();
        reset = 1'b0;
        set_dma(0, 0, '0, '0, 0);
        set_cpu(1, 0, 17'd5, '0);
        sample();
        chk1("t6_rvalid", dma_rvalid, 1'b0);
        chkw("t6_dma_rd", dma_rd, '0);
        chk1("t6_stall", cpu_stall, 1'b0);
        chkw("t6_adr", mem_adr, 17'd5);
        chkw("t6_cpu_rd", cpu_rd, 17'h1ABCD);
        tick();
        set_dma(1, 0, 17'd12, '0, 1);
        sample(); chk1("t6_no_force", dma_gnt, 1'b0);
        tick();
        set_cpu(0, 0, '0, '0);
        set_dma(0, 0, '0, '0, 0);
        tick();
        sample();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-ported data memory between the ASIP load/store port and a secondary DMA requester (frame/host loader). The ASIP port has priority. A wait counter bounds DMA starvation, and a beat counter caps DMA burst ownership. The block sits between the ASIP data port, the DMA engine and dataMemory, and drives the ASIP stall input.

Parameters:
WIDTH, 17, data and address width, matching the processor datapath.
MAX_WAIT, 8, maximum number of contended cycles the DMA waits before it is forced a grant. Must be >= 1.
BURST_MAX, 4, maximum number of consecutive DMA beats per ownership. Must be >= 1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
cpu_req  input  1  ASIP requests a data access this cycle
cpu_we  input  1  ASIP access is a write
cpu_adr  input  WIDTH  ASIP address
cpu_wd  input  WIDTH  ASIP write data
cpu_rd  output  WIDTH  read data to ASIP; equals mem_rd
cpu_stall  output  1  ASIP must hold its PC and instruction this cycle
dma_req  input  1  DMA requests a beat
dma_we  input  1  DMA beat is a write
dma_adr  input  WIDTH  DMA address
dma_wd  input  WIDTH  DMA write data
dma_last  input  1  current DMA beat is the final beat of its burst
dma_gnt  output  1  DMA beat is accepted this cycle
dma_rd  output  WIDTH  registered DMA read data
dma_rvalid  output  1  dma_rd is valid; one-cycle pulse
mem_we  output  1  data memory write enable
mem_adr  output  WIDTH  data memory address
mem_wd  output  WIDTH  data memory write data
mem_rd  input  WIDTH  data memory combinational read data

Behaviour:
- Memory model: combinational read; write occurs on the clk edge when mem_we=1. The arbiter grants exactly one requester per cycle, so no two writes can collide.
- State: owner ∈ {CPU_OWN, DMA_OWN}; wait_cnt in 0..MAX_WAIT; beat_cnt in 0..BURST_MAX.
- Reset (synchronous): owner=CPU_OWN, wait_cnt=0, beat_cnt=0, dma_rd=0, dma_rvalid=0. While reset is high, combinational outputs follow the CPU_OWN rules.
- CPU_OWN grant rule (combinational):
  - DMA wins iff dma_req && (!cpu_req || wait_cnt==MAX_WAIT).
  - Otherwise the CPU is served when cpu_req=1.
- DMA_OWN grant rule:
  - DMA wins iff dma_req=1.
  - If dma_req=0, the CPU is served this same cycle (abandoned burst).
- Outputs on a DMA win:
  - dma_gnt=1; mem_* driven from the dma_* inputs; mem_we=dma_we.
  - cpu_stall=cpu_req.
- Outputs on a CPU win:
  - dma_gnt=0, cpu_stall=0; mem_* driven from the cpu_* inputs; mem_we=cpu_we.
- No request: mem_we=0, mem_adr=0, mem_wd=0, dma_gnt=0, cpu_stall=0.
- wait_cnt, CPU_OWN only:
  - Increments, saturating at MAX_WAIT, when dma_req && cpu_req && DMA loses.
  - Clears on a DMA grant or when dma_req=0.
  - Held at 0 in DMA_OWN.
- Transitions after a DMA-granted beat:
  - If dma_last=1, or beat_cnt+1==BURST_MAX: next owner=CPU_OWN, beat_cnt=0.
  - Otherwise: next owner=DMA_OWN, beat_cnt=beat_cnt+1.
  - On entry to DMA_OWN from CPU_OWN, beat_cnt becomes 1.
- DMA_OWN with dma_req=0: next owner=CPU_OWN, beat_cnt=0.
- Read return to DMA: on the edge after a granted DMA read (dma_we=0), dma_rd<=mem_rd and dma_rvalid<=1. dma_rvalid is 0 otherwise; dma_rd holds its last value.
- ASIP read: cpu_rd=mem_rd. Valid only when cpu_req && !cpu_stall.
- Fairness: after a capped burst, the CPU owns the memory and the DMA re-enters the wait_cnt path, so the CPU gets up to MAX_WAIT cycles before the next forced grant.
- Reset mid-burst: the burst is aborted. Beats already written persist; the remaining beats are the DMA engine's responsibility to reissue.
- Simultaneous dma_last and cap on the same beat: single return to CPU_OWN, no double count.

Test Plan:
1. CPU only: cpu_req=1, we=1, adr=5, wd=0x1ABCD; next cycle read adr=5 -> mem_we=1 then mem_rd/cpu_rd=0x1ABCD, cpu_stall=0, dma_gnt=0 throughout.
2. DMA only, 3 read beats at adr 10,11,12 with dma_last on beat 3 -> dma_gnt=1 for 3 consecutive cycles; dma_rvalid=1 on each following cycle with the stored data; owner returns to CPU_OWN.
3. Contention, MAX_WAIT=8, both req continuously, single-beat DMA (dma_last=1) -> CPU served cycles 1-8; cycle 9 dma_gnt=1, cpu_stall=1; pattern repeats every 9 cycles.
4. Burst cap, BURST_MAX=4, DMA writes 6 beats with dma_last=0, cpu_req=1 -> DMA granted 4 consecutive beats with cpu_stall=1; then CPU served for 8 cycles; then DMA resumes with beat 5.
5. Abandoned burst: dma_req drops after beat 2 of 4 while cpu_req=1 -> CPU served that same cycle, cpu_stall=0; owner=CPU_OWN, beat_cnt=0.
6. Reset during beat 2 of a DMA read burst -> next cycle: owner=CPU_OWN, wait_cnt=0, dma_rvalid=0, dma_rd=0; cpu_req alone is served immediately.
